// File: rtl/alu_md_control.sv
// ALU control decode plus an iterative radix-2 multiply/divide sequencer with HI/LO registers.
// Divide support is compiled in only when the ALU_MD_DIV_EN macro is defined.
module alu_md_control #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_i,
  input  logic [1:0]       alu_op,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  output logic [3:0]       alu_ctrl,
  output logic             stall,
  output logic             md_busy,
  output logic             md_done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] mf_data
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;

  typedef enum logic [1:0] {IDLE = 2'd0, ITER = 2'd1, FIX = 2'd2} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH:0]    acc_q, acc_d;
  logic [WIDTH-1:0]  hi_q, hi_d;
  logic [WIDTH-1:0]  lo_q, lo_d;
  logic              neg_q, neg_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
`ifdef ALU_MD_DIV_EN
  logic              is_div_q, is_div_d;
  logic              rem_neg_q, rem_neg_d;
  logic              dz_q, dz_d;
  logic [WIDTH:0]    div_shift, div_diff;
  logic [WIDTH-1:0]  quo_fix, rem_fix;
`endif

  logic              is_rtype, is_mult, is_div, is_md;
  logic              op_signed, rs_neg, rt_neg;
  logic [WIDTH-1:0]  rs_abs, rt_abs;
  logic [WIDTH:0]    mul_sum;
  logic [2*WIDTH-1:0] prod, prod_fix;

  always_comb begin
    is_rtype = (alu_op == 2'b10);
    is_mult  = is_rtype && (funct == F_MULT || funct == F_MULTU);
`ifdef ALU_MD_DIV_EN
    is_div   = is_rtype && (funct == F_DIV || funct == F_DIVU);
`else
    is_div   = 1'b0;
`endif
    is_md    = is_mult || is_div || (is_rtype && (funct == F_MFHI || funct == F_MFLO));
  end

  always_comb begin
    alu_ctrl = 4'b0010;
    case (alu_op)
      2'b00: alu_ctrl = 4'b0010;
      2'b01: alu_ctrl = 4'b0110;
      2'b11: alu_ctrl = 4'b0010;
      default: begin
        case (funct)
          6'b100000, 6'b100001: alu_ctrl = 4'b0010;
          6'b100010, 6'b100011: alu_ctrl = 4'b0110;
          6'b100100:            alu_ctrl = 4'b0000;
          6'b100101:            alu_ctrl = 4'b0001;
          6'b101010:            alu_ctrl = 4'b0111;
          6'b000000:            alu_ctrl = 4'b0100;
          6'b000010:            alu_ctrl = 4'b0101;
          default:              alu_ctrl = 4'b0010;
        endcase
      end
    endcase
  end

  assign stall   = valid_i && (state_q != IDLE) && is_md;
  assign mf_data = (funct == F_MFHI) ? hi_q : lo_q;
  assign hi      = hi_q;
  assign lo      = lo_q;
  assign md_busy = busy_q;
  assign md_done = done_q;

  // Operands are held as magnitudes; signs are reapplied in FIX.
  always_comb begin
    op_signed = ~funct[0];
    rs_neg    = op_signed & rs_data[WIDTH-1];
    rt_neg    = op_signed & rt_data[WIDTH-1];
    rs_abs    = rs_neg ? -rs_data : rs_data;
    rt_abs    = rt_neg ? -rt_data : rt_data;
    mul_sum   = a_q[0] ? (acc_q + {1'b0, b_q}) : acc_q;
    prod      = {acc_q[WIDTH-1:0], a_q};
    prod_fix  = neg_q ? -prod : prod;
`ifdef ALU_MD_DIV_EN
    div_shift = {acc_q[WIDTH-1:0], a_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, b_q};
    quo_fix   = dz_q ? '1 : (neg_q ? -a_q : a_q);
    rem_fix   = rem_neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
`endif
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    neg_d   = neg_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef ALU_MD_DIV_EN
    is_div_d  = is_div_q;
    rem_neg_d = rem_neg_q;
    dz_d      = dz_q;
`endif
    case (state_q)
      IDLE: begin
        if (valid_i && (is_mult || is_div)) begin
          state_d = ITER;
          cnt_d   = CW'(WIDTH);
          a_d     = rs_abs;
          b_d     = rt_abs;
          acc_d   = '0;
          neg_d   = rs_neg ^ rt_neg;
          busy_d  = 1'b1;
`ifdef ALU_MD_DIV_EN
          is_div_d  = is_div;
          rem_neg_d = rs_neg;
          dz_d      = (rt_data == '0);
`endif
        end
      end
      ITER: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) state_d = FIX;
`ifdef ALU_MD_DIV_EN
        if (is_div_q) begin
          if (!div_diff[WIDTH]) begin
            acc_d = div_diff;
            a_d   = {a_q[WIDTH-2:0], 1'b1};
          end else begin
            acc_d = div_shift;
            a_d   = {a_q[WIDTH-2:0], 1'b0};
          end
        end else
`endif
        begin
          acc_d = {1'b0, mul_sum[WIDTH:1]};
          a_d   = {mul_sum[0], a_q[WIDTH-1:1]};
        end
      end
      FIX: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
`ifdef ALU_MD_DIV_EN
        if (is_div_q) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end else
`endif
        begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      neg_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef ALU_MD_DIV_EN
      is_div_q  <= 1'b0;
      rem_neg_q <= 1'b0;
      dz_q      <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      neg_q   <= neg_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef ALU_MD_DIV_EN
      is_div_q  <= is_div_d;
      rem_neg_q <= rem_neg_d;
      dz_q      <= dz_d;
`endif
    end
  end

endmodule

// File: tb/tb_alu_md_control.sv
// Scoreboard bench for alu_md_control: MD results are queued at issue and checked on md_done.
// Divide expectations follow the ALU_MD_DIV_EN macro.
module tb_alu_md_control;

  localparam int W = 32;

  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         valid_i;
  logic [1:0]   alu_op;
  logic [5:0]   funct;
  logic [W-1:0] rs_data, rt_data;
  logic [3:0]   alu_ctrl;
  logic         stall, md_busy, md_done;
  logic [W-1:0] hi, lo, mf_data;

  alu_md_control #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .alu_op(alu_op), .funct(funct),
    .rs_data(rs_data), .rt_data(rt_data), .alu_ctrl(alu_ctrl), .stall(stall),
    .md_busy(md_busy), .md_done(md_done), .hi(hi), .lo(lo), .mf_data(mf_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    int           due;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  typedef struct {
    logic [1:0] op;
    logic [5:0] f;
    logic [3:0] ctrl;
  } alu_vec_t;
  alu_vec_t tbl[11];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [1:0] op, input logic [5:0] f,
                               input logic [W-1:0] a, input logic [W-1:0] b);
    valid_i = v;
    alu_op  = op;
    funct   = f;
    rs_data = a;
    rt_data = b;
  endtask

  // Result appears with md_done at the negedge following edge (issue + W + 1).
  task automatic issueMd(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] eh, input logic [W-1:0] el);
    @(negedge clk);
    applyStimulus(1'b1, 2'b10, f, a, b);
    sb.push_back('{eh, el, cyc + W + 2});
    @(negedge clk);
    applyStimulus(1'b0, 2'b00, 6'd0, '0, '0);
  endtask

  task automatic waitIdle();
    int n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) checkOutput("scoreboard_drain", 64'(sb.size()), 64'd0);
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (md_done === 1'b1) begin
        if (sb.size() == 0) begin
          checkOutput("spurious_md_done", {63'd0, md_done}, 64'd0);
        end else begin
          mon_e = sb.pop_front();
          checkOutput("hi", {32'd0, hi}, {32'd0, mon_e.hi});
          checkOutput("lo", {32'd0, lo}, {32'd0, mon_e.lo});
          checkOutput("done_cycle", 64'(cyc), 64'(mon_e.due));
        end
      end else if (sb.size() != 0 && cyc > sb[0].due) begin
        checkOutput("md_done_timeout", {63'd0, md_done}, 64'd1);
        void'(sb.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    int issue_edge;

    tbl[0]  = '{2'b00, 6'b000000, 4'b0010};
    tbl[1]  = '{2'b01, 6'b000000, 4'b0110};
    tbl[2]  = '{2'b11, 6'b101010, 4'b0010};
    tbl[3]  = '{2'b10, 6'b100001, 4'b0010};
    tbl[4]  = '{2'b10, 6'b100010, 4'b0110};
    tbl[5]  = '{2'b10, 6'b100100, 4'b0000};
    tbl[6]  = '{2'b10, 6'b100101, 4'b0001};
    tbl[7]  = '{2'b10, 6'b101010, 4'b0111};
    tbl[8]  = '{2'b10, 6'b000000, 4'b0100};
    tbl[9]  = '{2'b10, 6'b000010, 4'b0101};
    tbl[10] = '{2'b10, 6'b111111, 4'b0010};

    rst_n = 1'b0;
    applyStimulus(1'b0, 2'b00, 6'd0, '0, '0);
    #1;
    checkOutput("reset_hi", {32'd0, hi}, 64'd0);
    checkOutput("reset_lo", {32'd0, lo}, 64'd0);
    checkOutput("reset_busy", {63'd0, md_busy}, 64'd0);
    checkOutput("reset_done", {63'd0, md_done}, 64'd0);

    // First issue presented right after release, taken on the first rising edge.
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    applyStimulus(1'b1, 2'b10, F_MULT, 32'hFFFF_FFFD, 32'd7);
    issue_edge = cyc + 1;
    sb.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFEB, cyc + W + 2});
    #1;
    checkOutput("alu_ctrl_mult", {60'd0, alu_ctrl}, 64'h2);
    checkOutput("stall_idle_issue", {63'd0, stall}, 64'd0);
    @(negedge clk);
    checkOutput("busy_after_issue", {63'd0, md_busy}, 64'd1);

    // Second mult while busy: must stall and be dropped.
    applyStimulus(1'b1, 2'b10, F_MULT, 32'd5, 32'd5);
    #1;
    checkOutput("stall_mult_busy", {63'd0, stall}, 64'd1);
    @(negedge clk);
    @(negedge clk);
    applyStimulus(1'b1, 2'b10, F_MFLO, '0, '0);
    #1;
    checkOutput("stall_mflo_busy", {63'd0, stall}, 64'd1);
    n = 0;
    while (stall === 1'b1 && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    checkOutput("stall_release_cycle", 64'(cyc), 64'(issue_edge + W + 1));
    checkOutput("mflo_new", {32'd0, mf_data}, 64'hFFFF_FFEB);
    applyStimulus(1'b1, 2'b10, F_MFHI, '0, '0);
    #1;
    checkOutput("mfhi_new", {32'd0, mf_data}, 64'hFFFF_FFFF);
    applyStimulus(1'b0, 2'b00, 6'd0, '0, '0);
    waitIdle();

    issueMd(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    waitIdle();
    issueMd(F_MULT,  32'h8000_0000, 32'd2, 32'hFFFF_FFFF, 32'h0000_0000);
    waitIdle();
    issueMd(F_MULTU, 32'h8000_0000, 32'd2, 32'h0000_0001, 32'h0000_0000);
    waitIdle();
    issueMd(F_MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001);
    waitIdle();
    issueMd(F_MULT,  32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000);
    waitIdle();

`ifdef ALU_MD_DIV_EN
    issueMd(F_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    waitIdle();
    issueMd(F_DIV,  32'd5, 32'd0, 32'h0000_0005, 32'hFFFF_FFFF);
    waitIdle();
    issueMd(F_DIV,  32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF);
    waitIdle();
    issueMd(F_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
    waitIdle();
    issueMd(F_DIV,  32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
    waitIdle();
    issueMd(F_DIVU, 32'd100, 32'd7, 32'h0000_0002, 32'h0000_000E);
    waitIdle();
    issueMd(F_DIVU, 32'hFFFF_FFFF, 32'h10, 32'h0000_000F, 32'h0FFF_FFFF);
    waitIdle();
`else
    @(negedge clk);
    applyStimulus(1'b1, 2'b10, F_DIV, 32'd100, 32'd7);
    @(negedge clk);
    applyStimulus(1'b0, 2'b00, 6'd0, '0, '0);
    checkOutput("div_disabled_busy", {63'd0, md_busy}, 64'd0);
    repeat (40) @(negedge clk);
    checkOutput("div_disabled_hi", {32'd0, hi}, 64'h1);
    checkOutput("div_disabled_lo", {32'd0, lo}, 64'h0);
`endif

    // Non-MD traffic during a busy multiply: decode only, no stall, no disturbance.
    issueMd(F_MULT, 32'd3, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 32'hFFFF_FFF4);
    for (int i = 0; i < 11; i++) begin
      applyStimulus(1'b1, tbl[i].op, tbl[i].f, 32'd9, 32'd9);
      #1;
      checkOutput($sformatf("alu_ctrl_%0d", i), {60'd0, alu_ctrl}, {60'd0, tbl[i].ctrl});
      checkOutput($sformatf("nonmd_stall_%0d", i), {63'd0, stall}, 64'd0);
      @(negedge clk);
    end
`ifndef ALU_MD_DIV_EN
    applyStimulus(1'b1, 2'b10, F_DIVU, 32'd9, 32'd3);
    #1;
    checkOutput("div_disabled_stall", {63'd0, stall}, 64'd0);
    @(negedge clk);
`endif
    applyStimulus(1'b0, 2'b00, 6'd0, '0, '0);
    waitIdle();

    // Abort mid-iteration: everything clears at once and no completion follows.
    @(negedge clk);
    applyStimulus(1'b1, 2'b10, F_MULTU, 32'd3, 32'd4);
    @(negedge clk);
    applyStimulus(1'b0, 2'b00, 6'd0, '0, '0);
    repeat (9) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("abort_hi", {32'd0, hi}, 64'd0);
    checkOutput("abort_lo", {32'd0, lo}, 64'd0);
    checkOutput("abort_busy", {63'd0, md_busy}, 64'd0);
    checkOutput("abort_done", {63'd0, md_done}, 64'd0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    checkOutput("post_abort_hi", {32'd0, hi}, 64'd0);
    checkOutput("post_abort_busy", {63'd0, md_busy}, 64'd0);

    issueMd(F_MULTU, 32'd3, 32'd4, 32'h0000_0000, 32'h0000_000C);
    waitIdle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
